four_bit_full_adder_subtractor: RTL and testbench
=================================================

Name: four_bit_full_adder_subtractor

Overview:
Registered 4-bit ripple-carry adder/subtractor with carry/borrow-in, built from four 1-bit full-adder stages with B-side conditional inversion. A mode bit selects add or subtract. Result, carry/borrow, signed-overflow and zero flags are captured in an output register one clock after the operands are presented. Used as a small ALU datapath slice.

Parameters:
none (width fixed at 4)

Ports:
clk      input   1  rising-edge clock
rst      input   1  asynchronous, active-high reset
a        input   4  operand A (unsigned or two's complement)
b        input   4  operand B
cin      input   1  carry-in when adding; borrow-in when subtracting
control  input   1  0 = add, 1 = subtract
result   output  4  registered 4-bit sum/difference
cout     output  1  registered carry-out (add) or borrow-out (subtract), active high in both modes
overflow output  1  registered two's-complement overflow flag
zero     output  1  registered flag, 1 when result == 4'b0000

Behaviour:
- Clocking: one clock; rst asynchronous, active-high; polarity and synchronicity are fixed.
- Reset: while rst=1, result=4'b0000, cout=0, overflow=0, zero=1 (consistent with result=0), immediately and independent of clk.
- Combinational core: 4 full-adder stages, bit i computes s_i and c_(i+1).
  - Stage B input = b_i XOR control.
  - Stage-0 carry-in = cin XOR control.
- Add (control=0): {c4, s} = a + b + cin, with 5-bit result.
  - cout = c4.
- Subtract (control=1): s = a - b - cin (mod 16), computed as a + ~b + ~cin.
  - cout = NOT c4, i.e. 1 exactly when a < b + cin (unsigned borrow).
- overflow = c4 XOR c3, the carry into and out of bit 3.
  - Equivalent to the signed result falling outside [-8, 7].
- zero = (s == 0), evaluated on the combinational sum.
- Latency: inputs sampled at a rising edge appear on the outputs after that edge (1 cycle). Outputs hold between edges.
- No enable and no handshake: every edge captures.
- Reset deassertion: the first capture occurs at the next rising edge.
- Reset mid-operation: outputs clear at once, and the pending operation is discarded.
- All combinations of a, b, cin and control are legal. Wrap-around is modulo 16, with the carry/borrow reported on cout.

Test Plan:
- Reset: assert rst between edges -> outputs go to result=0000, cout=0, zero=1, overflow=0 without waiting for a clock edge. Release rst -> outputs hold until the next edge.
- Add cases, each checked one edge later:
  - a=0101, b=0011, cin=0, control=0 -> result=1000, cout=0, overflow=1.
  - a=0111, b=0111, cin=0, control=0 -> result=1110, cout=0, overflow=1.
  - a=1001, b=0110, cin=0, control=0 -> result=1111, cout=0, overflow=0.
- Add with carry-in and wrap: a=1111, b=0001, cin=1, control=0 -> result=0001, cout=1, overflow=0, zero=0.
- Subtract cases:
  - a=0110, b=0011, cin=0, control=1 -> result=0011, cout=0.
  - a=1000, b=0001, cin=1, control=1 -> result=0110, cout=0, overflow=1.
  - a=1010, b=0110, cin=0, control=1 -> result=0100, cout=0, overflow=1.
- Borrow-out and zero:
  - a=0100, b=1001, cin=0, control=1 -> result=1011, cout=1, overflow=1.
  - a=0101, b=0101, cin=0, control=1 -> result=0000, zero=1, cout=0.
- Exhaustive: all 1024 combinations of a, b, cin and control against the reference model, checked with 1-cycle latency. Assert rst mid-sequence and check outputs clear immediately.

Source files
------------

// File: rtl/four_bit_full_adder_subtractor_if.sv
// Operand and flag bundle for the 4-bit adder/subtractor slice.
// The master drives operands and mode; the slave returns the registered result and flags.
interface four_bit_full_adder_subtractor_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       control;
  logic [3:0] result;
  logic       cout;
  logic       overflow;
  logic       zero;

  modport master (
    output a, b, cin, control,
    input  result, cout, overflow, zero
  );

  modport slave (
    input  a, b, cin, control,
    output result, cout, overflow, zero
  );
endinterface

// File: rtl/four_bit_full_adder_subtractor.sv
// Registered 4-bit ripple-carry adder/subtractor with carry/borrow-in.
// It produces the result together with carry/borrow, signed-overflow and zero flags, one clock after the operands.
module four_bit_full_adder_subtractor (
  input logic                            clk,
  input logic                            rst,
  four_bit_full_adder_subtractor_if.slave bus
);

  // One full-adder stage: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic c);
    logic s;
    logic co;
    s  = x ^ y ^ c;
    co = (x & y) | (x & c) | (y & c);
    return {co, s};
  endfunction

  // Four chained stages: returns {c4, c3, sum[3:0]}.
  function automatic logic [5:0] ripple(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] s;
    logic [1:0] st;
    logic       c;
    logic       c3;
    c  = c0;
    c3 = 1'b0;
    s  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      st   = full_adder(x[i], y[i], c);
      s[i] = st[0];
      if (i == 3) begin
        c3 = c;
      end else begin
        c3 = c3;
      end
      c = st[1];
    end
    return {c, c3, s};
  endfunction

  logic [3:0] b_eff_s;
  logic       c0_s;
  logic [5:0] core_s;
  logic [3:0] sum_s;
  logic       cout_s;
  logic       overflow_s;
  logic       zero_s;

  logic [3:0] result_r;
  logic       cout_r;
  logic       overflow_r;
  logic       zero_r;

  // Subtraction inverts the B side and the carry-in, so cout is flipped back into an active-high borrow.
  always_comb begin
    b_eff_s    = bus.b ^ {4{bus.control}};
    c0_s       = bus.cin ^ bus.control;
    core_s     = ripple(bus.a, b_eff_s, c0_s);
    sum_s      = core_s[3:0];
    cout_s     = core_s[5] ^ bus.control;
    overflow_s = core_s[5] ^ core_s[4];
    zero_s     = (sum_s == 4'b0000);
  end

  // Output register: it captures on every edge and clears at once on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r   <= 4'b0000;
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b1;
    end else begin
      result_r   <= sum_s;
      cout_r     <= cout_s;
      overflow_r <= overflow_s;
      zero_r     <= zero_s;
    end
  end

  assign bus.result   = result_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = overflow_r;
  assign bus.zero     = zero_r;

endmodule

// File: tb/tb_four_bit_full_adder_subtractor.sv
// Self-checking bench for four_bit_full_adder_subtractor.
// It runs directed vectors, reset corner cases and an exhaustive sweep through a scoreboard queue.
module tb_four_bit_full_adder_subtractor;

  logic clk;
  logic rst;

  four_bit_full_adder_subtractor_if intf ();

  four_bit_full_adder_subtractor dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       ctrl;
    logic [6:0] exp;  // {result, cout, overflow, zero}
  } vec_t;

  localparam logic [6:0] RESET_VAL = {4'b0000, 1'b0, 1'b0, 1'b1};

  vec_t       dir [9];
  logic [6:0] exp_q [$];
  logic [6:0] dut_out;
  int         n_cmp;
  int         n_err;

  assign dut_out = {intf.result, intf.cout, intf.overflow, intf.zero};

  // Independent arithmetic reference that uses integer math, not a gate model.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin, input logic ctrl);
    int         ua;
    int         ub;
    int         sa;
    int         sb;
    int         u;
    int         s;
    logic [3:0] r;
    logic       co;
    logic       ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!ctrl) begin
      u  = ua + ub + int'(cin);
      s  = sa + sb + int'(cin);
      co = (u > 15);
    end else begin
      u  = ua - ub - int'(cin);
      s  = sa - sb - int'(cin);
      co = (ua < ub + int'(cin));
    end
    r  = u[3:0];
    ov = (s > 7) || (s < -8);
    return {r, co, ov, (r == 4'b0000)};
  endfunction

  task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got result=%b cout=%b ovf=%b zero=%b, expected result=%b cout=%b ovf=%b zero=%b",
               name, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic ctrl, input logic [6:0] exp);
    @(negedge clk);
    intf.a       = a;
    intf.b       = b;
    intf.cin     = cin;
    intf.control = ctrl;
    exp_q.push_back(exp);
  endtask

  task automatic check_out(input string name);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty when output was due", name);
    end else begin
      cmp(name, dut_out, exp_q.pop_front());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    dir[0] = '{4'b0101, 4'b0011, 1'b0, 1'b0, {4'b1000, 1'b0, 1'b1, 1'b0}};
    dir[1] = '{4'b0111, 4'b0111, 1'b0, 1'b0, {4'b1110, 1'b0, 1'b1, 1'b0}};
    dir[2] = '{4'b1001, 4'b0110, 1'b0, 1'b0, {4'b1111, 1'b0, 1'b0, 1'b0}};
    dir[3] = '{4'b1111, 4'b0001, 1'b1, 1'b0, {4'b0001, 1'b1, 1'b0, 1'b0}};
    dir[4] = '{4'b0110, 4'b0011, 1'b0, 1'b1, {4'b0011, 1'b0, 1'b0, 1'b0}};
    dir[5] = '{4'b1000, 4'b0001, 1'b1, 1'b1, {4'b0110, 1'b0, 1'b1, 1'b0}};
    dir[6] = '{4'b1010, 4'b0110, 1'b0, 1'b1, {4'b0100, 1'b0, 1'b1, 1'b0}};
    dir[7] = '{4'b0100, 4'b1001, 1'b0, 1'b1, {4'b1011, 1'b1, 1'b1, 1'b0}};
    dir[8] = '{4'b0101, 4'b0101, 1'b0, 1'b1, {4'b0000, 1'b0, 1'b0, 1'b1}};

    // Reset is held across an edge while the inputs are non-zero, so nothing may be captured.
    rst          = 1'b1;
    intf.a       = 4'b0101;
    intf.b       = 4'b0011;
    intf.cin     = 1'b1;
    intf.control = 1'b0;
    #2;
    cmp("reset_initial", dut_out, RESET_VAL);
    @(posedge clk);
    #1;
    cmp("reset_held_edge", dut_out, RESET_VAL);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("reset_release_hold", dut_out, RESET_VAL);

    for (int k = 0; k < 9; k++) begin
      drive(dir[k].a, dir[k].b, dir[k].cin, dir[k].ctrl, dir[k].exp);
      check_out($sformatf("dir%0d", k));
    end

    // Reset asserted between edges: the outputs clear at once, and the pending operands are dropped.
    drive(4'b1111, 4'b0001, 1'b1, 1'b0, {4'b0001, 1'b1, 1'b0, 1'b0});
    check_out("pre_reset_op");
    @(negedge clk);
    intf.a       = 4'b0111;
    intf.b       = 4'b0111;
    intf.cin     = 1'b0;
    intf.control = 1'b0;
    rst          = 1'b1;
    #1;
    cmp("mid_reset_async", dut_out, RESET_VAL);
    #2;
    rst = 1'b0;
    #1;
    cmp("mid_reset_hold", dut_out, RESET_VAL);
    exp_q.push_back({4'b1110, 1'b0, 1'b1, 1'b0});
    check_out("first_capture_after_reset");

    // Exhaustive sweep; reset is pulsed partway through, and its pending entry is discarded.
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] v;
      v = i[9:0];
      if (i == 600) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp("sweep_reset_async", dut_out, RESET_VAL);
        @(posedge clk);
        #1;
        cmp("sweep_reset_edge", dut_out, RESET_VAL);
        exp_q.delete();
        rst = 1'b0;
      end
      drive(v[3:0], v[7:4], v[8], v[9], model(v[3:0], v[7:4], v[8], v[9]));
      check_out($sformatf("sweep a=%b b=%b cin=%b ctrl=%b", v[3:0], v[7:4], v[8], v[9]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
